// File: rtl/snake_cpu_debug_scan_master.sv
// Virtual-JTAG style debug scan master: runs one UIR/CDR/SDR/UDR sequence per
// accepted command and returns the captured data-register contents.
// Optional feature: define SNAKE_DEBUG_SCAN_RTI_EN to insert a run-test-idle
// dwell of RTI_CYCLES cycles between update and response.
module snake_cpu_debug_scan_master #(
    parameter int unsigned DR_WIDTH   = 38,
    parameter int unsigned RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic [1:0]          ir_in,
    input  logic [1:0]          ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                tdi,
    input  logic                tdo
);

    localparam int unsigned CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
    localparam int unsigned RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RSP  = 3'd5
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
        ,
        S_RTI  = 3'd6
`endif
    } state_t;

    state_t              state;
    logic [DR_WIDTH-1:0] sr;
    logic [CNT_W-1:0]    bit_cnt;
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
    logic [RTI_W-1:0]    rti_cnt;
`else
    // Dwell length has no effect without the run-test-idle feature.
    logic                unused_rti_cycles;
    assign unused_rti_cycles = ^RTI_CYCLES;
`endif

    // Serial data leaves from the bottom of the shift register only while shifting.
    assign tdi = vs_sdr & sr[0];

    // Scan sequencer; qualifier outputs are registered alongside each transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            sr             <= '0;
            bit_cnt        <= '0;
            rsp_data       <= '0;
            rsp_ir_out     <= 2'b00;
            ir_in          <= 2'b00;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
            rti_cnt        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ir_in          <= cmd_ir;
                        sr             <= cmd_data;
                        cmd_ready      <= 1'b0;
                        jtag_state_rti <= 1'b0;
                        vs_uir         <= 1'b1;
                        state          <= S_UIR;
                    end
                end
                S_UIR: begin
                    vs_uir <= 1'b0;
                    vs_cdr <= 1'b1;
                    state  <= S_CDR;
                end
                S_CDR: begin
                    rsp_ir_out <= ir_out;
                    bit_cnt    <= '0;
                    vs_cdr     <= 1'b0;
                    vs_sdr     <= 1'b1;
                    state      <= S_SDR;
                end
                S_SDR: begin
                    sr <= {tdo, sr[DR_WIDTH-1:1]};
                    if (bit_cnt == CNT_W'(DR_WIDTH - 1)) begin
                        vs_sdr <= 1'b0;
                        vs_udr <= 1'b1;
                        state  <= S_UDR;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_UDR: begin
                    rsp_data <= sr;
                    vs_udr   <= 1'b0;
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
                    rti_cnt        <= '0;
                    jtag_state_rti <= 1'b1;
                    state          <= S_RTI;
`else
                    rsp_valid <= 1'b1;
                    state     <= S_RSP;
`endif
                end
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
                S_RTI: begin
                    if (rti_cnt == RTI_W'(RTI_CYCLES - 1)) begin
                        jtag_state_rti <= 1'b0;
                        rsp_valid      <= 1'b1;
                        state          <= S_RSP;
                    end else begin
                        rti_cnt <= rti_cnt + RTI_W'(1);
                    end
                end
`endif
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid      <= 1'b0;
                        cmd_ready      <= 1'b1;
                        jtag_state_rti <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    cmd_ready      <= 1'b1;
                    rsp_valid      <= 1'b0;
                    vs_uir         <= 1'b0;
                    vs_cdr         <= 1'b0;
                    vs_sdr         <= 1'b0;
                    vs_udr         <= 1'b0;
                    jtag_state_rti <= 1'b1;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_cpu_debug_scan_master.sv
// Randomized scoreboard bench for snake_cpu_debug_scan_master with a simple
// slave model (loopback, tied-high or patterned tdo).
module tb_snake_cpu_debug_scan_master;

    localparam int unsigned W = 38;
`ifdef SNAKE_DEBUG_SCAN_RTI_EN
    localparam int unsigned RTI = 2;
`else
    localparam int unsigned RTI = 0;
`endif
    localparam int unsigned LAT = W + 3 + RTI;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_ir;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic [1:0]   rsp_ir_out;
    logic [1:0]   ir_in;
    logic [1:0]   ir_out = 2'b00;
    logic         vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic         jtag_state_rti;
    logic         tdi;
    logic         tdo;

    snake_cpu_debug_scan_master #(.DR_WIDTH(W), .RTI_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
        .ir_in(ir_in), .ir_out(ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        chkw(nm, 64'(act), 64'(expv));
    endtask

    // Expected scoreboard entries, pushed at command acceptance.
    typedef struct {
        logic [1:0]   ir;
        logic [W-1:0] rsp;
        logic [1:0]   irv;
        int           acc;
    } exp_t;
    exp_t sb[$];

    // Slave model configuration for the scan in flight.
    int           mode = 0;          // 0 loopback, 1 tdo tied high, 2 pattern
    logic [W-1:0] pat = '0;
    logic [1:0]   irv = 2'b00;
    logic [W-1:0] cur_data = '0;
    logic         stall = 1'b0;
    logic         tdo_drv = 1'b0;
    int           k = 0;
    int           n_rsp = 0;

    assign tdo = (mode == 0) ? tdi : tdo_drv;

    // Slave model: present tdo bits during shift and status only during capture.
    always @(negedge clk) begin
        if (vs_sdr) begin
            if (mode == 1)      tdo_drv = 1'b1;
            else if (k < int'(W)) tdo_drv = pat[k];
            else                tdo_drv = 1'b0;
            k++;
        end else begin
            k = 0;
            tdo_drv = 1'($urandom);
        end
        ir_out = vs_cdr ? irv : 2'b00;
    end

    // Consumer: optionally refuse the response for 10 cycles, then random readiness.
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rsp_valid) stall_cnt = 0;
        if (stall && stall_cnt < 10) rsp_ready = 1'b0;
        else                         rsp_ready = ($urandom_range(0, 2) != 0);
        if (rsp_valid) stall_cnt++;
    end

    // Monitor: per-cycle protocol checks and response comparison against the scoreboard.
    int           n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    logic         rv_prev = 1'b0;
    logic [W-1:0] held_data = '0;
    logic [1:0]   held_ir = 2'b00;
    exp_t         e;
    always @(negedge clk) begin
        if (!reset_n) begin
            n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
            rv_prev = 1'b0;
        end else begin
            logic busy;
            busy = vs_uir | vs_cdr | vs_sdr | vs_udr | rsp_valid;
            chkw("vs_onehot", 64'($countones({vs_uir, vs_cdr, vs_sdr, vs_udr}) <= 1), 64'd1);
            if (busy) begin
                chk1("cmd_ready_busy", cmd_ready, 1'b0);
                chk1("rti_busy", jtag_state_rti, 1'b0);
            end else begin
                chk1("rti_idle_or_dwell", jtag_state_rti, 1'b1);
                if (!cmd_ready) n_rti++;
            end
            if (vs_sdr) begin
                if (n_sdr < int'(W)) chk1("tdi_bit", tdi, cur_data[n_sdr]);
                n_sdr++;
            end else begin
                chk1("tdi_quiet", tdi, 1'b0);
            end
            if (vs_uir) n_uir++;
            if (vs_cdr) n_cdr++;
            if (vs_udr) n_udr++;
            if (rsp_valid && !rv_prev) begin
                chkw("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chkw("latency", 64'(cyc - sb[0].acc), 64'(LAT));
            end
            if (rsp_valid && rv_prev) begin
                chkw("rsp_data_stable", 64'(rsp_data), 64'(held_data));
                chkw("rsp_ir_stable", 64'(rsp_ir_out), 64'(held_ir));
            end
            if (rsp_valid) begin
                held_data = rsp_data;
                held_ir   = rsp_ir_out;
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chkw("rsp_data", 64'(rsp_data), 64'(e.rsp));
                chkw("rsp_ir_out", 64'(rsp_ir_out), 64'(e.irv));
                chkw("ir_in", 64'(ir_in), 64'(e.ir));
                chkw("n_vs_uir", 64'(n_uir), 64'd1);
                chkw("n_vs_cdr", 64'(n_cdr), 64'd1);
                chkw("n_vs_sdr", 64'(n_sdr), 64'(W));
                chkw("n_vs_udr", 64'(n_udr), 64'd1);
                chkw("n_rti_dwell", 64'(n_rti), 64'(RTI));
                n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
                n_rsp++;
            end
            rv_prev = rsp_valid;
        end
    end

    // Reference: each response bit i is the tdo value seen on shift cycle i.
    function automatic logic [W-1:0] expect_rsp(input int m, input logic [W-1:0] d,
                                                 input logic [W-1:0] p);
        if (m == 0) return d;
        if (m == 1) return '1;
        return p;
    endfunction

    task automatic check_reset(input string tag);
        chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chkw({tag, "_vs"}, 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
        chk1({tag, "_tdi"}, tdi, 1'b0);
        chk1({tag, "_rti"}, jtag_state_rti, 1'b1);
        chkw({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chkw({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
        chkw({tag, "_ir_in"}, 64'(ir_in), 64'd0);
    endtask

    task automatic scan(input logic [1:0] ir, input logic [W-1:0] d, input int m,
                        input logic [W-1:0] p, input logic [1:0] iv,
                        input logic stl, input logic abort);
        logic got;
        int   start;
        mode = m; pat = p; irv = iv; cur_data = d; stall = stl;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_ir = ir; cmd_data = d;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        chk1("accept_ready", got, 1'b1);
        if (!got) begin cmd_valid = 1'b0; return; end
        if (!abort) sb.push_back('{ir: ir, rsp: expect_rsp(m, d, p), irv: iv, acc: cyc + 1});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (abort) begin
            repeat (22) @(posedge clk);
            #1;
            chk1("abort_in_sdr", vs_sdr, 1'b1);
            reset_n = 1'b0;
            @(negedge clk);
            check_reset("abort_rst");
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                chk1("abort_no_udr", vs_udr, 1'b0);
                chk1("abort_no_rsp", rsp_valid, 1'b0);
                chk1("abort_ready", cmd_ready, 1'b1);
            end
            return;
        end
        start = n_rsp;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (n_rsp != start) break;
            cmd_valid = stl ? 1'b1 : ($urandom_range(0, 3) == 0);
            cmd_ir    = 2'($urandom);
            cmd_data  = W'({$urandom, $urandom});
        end
        cmd_valid = 1'b0;
        chk1("rsp_handshake_seen", n_rsp != start, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk1("ready_after_release", cmd_ready, 1'b1);

        scan(2'b01, 38'h2A_5A5A_5A5A, 0, '0, 2'b00, 1'b0, 1'b0);
        scan(2'b11, '0, 1, '0, 2'b01, 1'b0, 1'b0);
        scan(2'b10, W'({$urandom, $urandom}), 2, W'({$urandom, $urandom}), 2'b10, 1'b0, 1'b0);
        scan(2'b01, W'({$urandom, $urandom}), 2, W'({$urandom, $urandom}), 2'b11, 1'b1, 1'b0);
        scan(2'b11, W'({$urandom, $urandom}), 0, '0, 2'b10, 1'b0, 1'b1);
        scan(2'b10, 38'h15_A5A5_A5A5, 0, '0, 2'b01, 1'b0, 1'b0);
        for (int n = 0; n < 25; n++) begin
            scan(2'($urandom), W'({$urandom, $urandom}), $urandom_range(0, 2),
                 W'({$urandom, $urandom}), 2'($urandom), ($urandom_range(0, 4) == 0), 1'b0);
        end
        repeat (5) @(posedge clk);
        chkw("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/snake_cpu_debug_scan_master.md
SNAKE_CPU_DEBUG_SCAN_MASTER -- requirements
Module: snake_cpu_debug_scan_master

Interface
REQ-001 Parameter DR_WIDTH, 38, data-register scan length in bits (legal 2..64).
REQ-002 Parameter RTI_CYCLES, 2, run-test-idle dwell cycles after update (used only when the configuration macro is defined).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  scan request present.
REQ-006 cmd_ready  output  1  block idle and accepting a request.
REQ-007 cmd_ir  input  2  virtual IR value for the scan.
REQ-008 cmd_data  input  DR_WIDTH  data shifted into slave, LSB first.
REQ-009 rsp_valid  output  1  scan result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  DR_WIDTH  bits shifted out of slave; first bit received in bit 0.
REQ-012 rsp_ir_out  output  2  slave ir_out sampled during capture.
REQ-013 ir_in  output  2  virtual IR presented to slave.
REQ-014 ir_out  input  2  status from slave.
REQ-015 vs_uir, vs_cdr, vs_sdr, vs_udr  output  1 each  virtual-state qualifiers.
REQ-016 jtag_state_rti  output  1  run-test-idle indicator.
REQ-017 tdi  output  1  serial data to slave.
REQ-018 tdo  input  1  serial data from slave.

Function
REQ-019 States: IDLE, UIR, CDR, SDR, UDR, RTI (macro only), RSP; exactly one of vs_uir/vs_cdr/vs_sdr/vs_udr high in its matching state, all low otherwise.
REQ-020 IDLE: cmd_ready=1; handshake on cmd_valid&cmd_ready latches cmd_ir into ir_in and cmd_data into shift register sr, next state UIR.
REQ-021 UIR lasts 1 cycle, ir_in stable from this cycle until next accepted command; then CDR.
REQ-022 CDR lasts 1 cycle; ir_out sampled into rsp_ir_out at its end; then SDR.
REQ-023 SDR lasts exactly DR_WIDTH cycles; tdi=sr[0] combinationally; each SDR edge sr <= {tdo, sr[DR_WIDTH-1:1]}; bit counter clears on entry, saturates at DR_WIDTH-1 then exits to UDR.
REQ-024 UDR lasts 1 cycle; rsp_data <= sr; next RTI (macro) or RSP.
REQ-025 RSP: rsp_valid=1 held, rsp_data/rsp_ir_out stable, until rsp_valid&rsp_ready, then IDLE (cmd_ready=1 next cycle; no same-cycle accept).
REQ-026 cmd_ready=0 in every state except IDLE; cmd_valid while busy is ignored, not queued.
REQ-027 Accept-to-rsp_valid latency = DR_WIDTH+3 cycles (no macro), DR_WIDTH+3+RTI_CYCLES (macro).
REQ-028 tdi=0 outside SDR; jtag_state_rti=1 in IDLE and RTI, 0 elsewhere.

Reset
REQ-029 reset_n low, any time including mid-scan: state IDLE, sr/rsp_data/ir_in/rsp_ir_out/counters 0, rsp_valid 0, all vs_* 0, tdi 0, jtag_state_rti 1, cmd_ready 1 on first edge after release.
REQ-030 Aborted scan produces no response; slave sees no vs_udr.

Configuration
REQ-031 Macro SNAKE_DEBUG_SCAN_RTI_EN defined: RTI state after UDR, held RTI_CYCLES cycles with jtag_state_rti=1, then RSP.
REQ-032 Macro undefined: RTI state, its counter and RTI_CYCLES usage absent; UDR goes directly to RSP.

Verification
REQ-033 DR_WIDTH=38, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A, tdo looped from tdi -> ir_in=01, rsp_data=38'h2A_5A5A_5A5A, rsp_valid at accept+41 (no macro).
REQ-034 tdo tied 1, cmd_data=0 -> tdi 0 for 38 SDR cycles, rsp_data=38'h3F_FFFF_FFFF; exactly one vs_uir, one vs_cdr, 38 vs_sdr, one vs_udr pulse.
REQ-035 ir_out=2'b10 during CDR, 2'b00 elsewhere -> rsp_ir_out=2'b10.
REQ-036 rsp_ready held 0 for 10 cycles, cmd_valid pulsed meanwhile -> rsp_valid/rsp_data stable, cmd_ready 0, second command not accepted until after response handshake.
REQ-037 reset_n pulsed low at SDR cycle 20 -> no vs_udr, rsp_valid 0, cmd_ready 1 after release, next scan completes correctly.
REQ-038 Macro defined, RTI_CYCLES=2 -> jtag_state_rti high 2 cycles after vs_udr, rsp_valid at accept+43.
